// File: rtl/dispatch_queue.sv
// In-order issue buffer between rename/decode and the RS/SLB. Waiting entries
// snoop the CDB channels every cycle so operands arrive while they queue.
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int CDB_N  = 2,
  parameter int ROB_W  = 4,
  parameter int OPT_W  = 6,
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rb,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_is_ls,
  input  logic                    in_is_ld,
  input  logic [OPT_W-1:0]        in_opt,
  input  logic [ROB_W-1:0]        in_src1,
  input  logic [ROB_W-1:0]        in_src2,
  input  logic [WORD_W-1:0]       in_val1,
  input  logic [WORD_W-1:0]       in_val2,
  input  logic [WORD_W-1:0]       in_imm,
  input  logic [ROB_W-1:0]        in_rob_idx,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]  cdb_src,
  input  logic [CDB_N*WORD_W-1:0] cdb_val,
  input  logic                    rs_full,
  input  logic                    slb_full,
  output logic                    rs_ena,
  output logic                    slb_ena,
  output logic [OPT_W-1:0]        out_opt,
  output logic [ROB_W-1:0]        out_src1,
  output logic [ROB_W-1:0]        out_src2,
  output logic [WORD_W-1:0]       out_val1,
  output logic [WORD_W-1:0]       out_val2,
  output logic [WORD_W-1:0]       out_imm,
  output logic [ROB_W-1:0]        out_rob_idx,
  output logic                    out_is_ld,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              is_ls;
    logic              is_ld;
    logic [OPT_W-1:0]  opt;
    logic [ROB_W-1:0]  src1;
    logic [ROB_W-1:0]  src2;
    logic [WORD_W-1:0] val1;
    logic [WORD_W-1:0] val2;
    logic [WORD_W-1:0] imm;
    logic [ROB_W-1:0]  rob_idx;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             ent_snp [DEPTH];
  ent_t             in_ent, in_snp, head_ent;
  ent_t             out_q, out_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rs_ena_q, rs_ena_d, slb_ena_q, slb_ena_d;
  logic             iss, enq;

  // Lowest-numbered matching channel wins; src 0 means "already ready".
  function automatic logic [ROB_W+WORD_W-1:0] snoop(
    input logic [ROB_W-1:0]        src,
    input logic [WORD_W-1:0]       val,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*ROB_W-1:0]  s,
    input logic [CDB_N*WORD_W-1:0] d
  );
    logic [ROB_W-1:0]  src_n;
    logic [WORD_W-1:0] val_n;
    logic              hit;
    src_n = src;
    val_n = val;
    hit   = 1'b0;
    for (int i = 0; i < CDB_N; i++) begin
      if (!hit && src != '0 && v[i] && s[i*ROB_W +: ROB_W] == src) begin
        hit   = 1'b1;
        src_n = '0;
        val_n = d[i*WORD_W +: WORD_W];
      end
    end
    return {src_n, val_n};
  endfunction

  function automatic ent_t snoop_ent(
    input ent_t                    e,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*ROB_W-1:0]  s,
    input logic [CDB_N*WORD_W-1:0] d
  );
    ent_t r;
    r = e;
    {r.src1, r.val1} = snoop(e.src1, e.val1, v, s, d);
    {r.src2, r.val2} = snoop(e.src2, e.val2, v, s, d);
    return r;
  endfunction

  // in_valid/in_ready: a bundle transfers at an edge where both are high;
  // in_ready depends only on the registered count, so issue gives no credit.
  assign in_ready = (count_q != CNT_W'(DEPTH));

  always_comb begin
    in_ent         = '0;
    in_ent.is_ls   = in_is_ls;
    in_ent.is_ld   = in_is_ld;
    in_ent.opt     = in_opt;
    in_ent.src1    = in_src1;
    in_ent.src2    = in_src2;
    in_ent.val1    = in_val1;
    in_ent.val2    = in_val2;
    in_ent.imm     = in_imm;
    in_ent.rob_idx = in_rob_idx;
    in_snp = snoop_ent(in_ent, cdb_valid, cdb_src, cdb_val);
    for (int i = 0; i < DEPTH; i++) begin
      ent_snp[i] = snoop_ent(ent_q[i], cdb_valid, cdb_src, cdb_val);
    end
    head_ent = ent_snp[head_q];
    iss = (count_q != '0) && (head_ent.is_ls ? !slb_full : !rs_full);
    enq = in_valid && in_ready;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    out_d     = out_q;
    rs_ena_d  = 1'b0;
    slb_ena_d = 1'b0;
    if (rb) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_snp[i];
      if (iss) begin
        out_d     = head_ent;
        rs_ena_d  = !head_ent.is_ls;
        slb_ena_d = head_ent.is_ls;
        head_d    = head_q + PTR_W'(1);
      end
      if (enq) begin
        ent_d[tail_q] = in_snp;
        tail_d        = tail_q + PTR_W'(1);
      end
      case ({enq, iss})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      rs_ena_q  <= 1'b0;
      slb_ena_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_q     <= out_d;
      rs_ena_q  <= rs_ena_d;
      slb_ena_q <= slb_ena_d;
    end
  end

  assign rs_ena      = rs_ena_q;
  assign slb_ena     = slb_ena_q;
  assign out_opt     = out_q.opt;
  assign out_src1    = out_q.src1;
  assign out_src2    = out_q.src2;
  assign out_val1    = out_q.val1;
  assign out_val2    = out_q.val2;
  assign out_imm     = out_q.imm;
  assign out_rob_idx = out_q.rob_idx;
  assign out_is_ld   = out_q.is_ld;
  assign count       = count_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: expected issued bundles are queued when offered and
// compared, in order, each time rs_ena or slb_ena fires.
module tb_dispatch_queue;
  localparam int DEPTH  = 4;
  localparam int CDB_N  = 2;
  localparam int ROB_W  = 4;
  localparam int OPT_W  = 6;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic              is_ls;
    logic              is_ld;
    logic [OPT_W-1:0]  opt;
    logic [ROB_W-1:0]  rob;
    logic [ROB_W-1:0]  src1;
    logic [ROB_W-1:0]  src2;
    logic [WORD_W-1:0] val1;
    logic [WORD_W-1:0] val2;
    logic [WORD_W-1:0] imm;
  } bundle_t;
  localparam int EXP_W = $bits(bundle_t);

  logic                    clk = 1'b0;
  logic                    rst, rdy, rb, in_valid, in_ready, in_is_ls, in_is_ld;
  logic [OPT_W-1:0]        in_opt;
  logic [ROB_W-1:0]        in_src1, in_src2, in_rob_idx;
  logic [WORD_W-1:0]       in_val1, in_val2, in_imm;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*ROB_W-1:0]  cdb_src;
  logic [CDB_N*WORD_W-1:0] cdb_val;
  logic                    rs_full, slb_full, rs_ena, slb_ena, out_is_ld;
  logic [OPT_W-1:0]        out_opt;
  logic [ROB_W-1:0]        out_src1, out_src2, out_rob_idx;
  logic [WORD_W-1:0]       out_val1, out_val2, out_imm;
  logic [$clog2(DEPTH):0]  count;

  dispatch_queue #(.DEPTH(DEPTH), .CDB_N(CDB_N), .ROB_W(ROB_W), .OPT_W(OPT_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_ls(in_is_ls), .in_is_ld(in_is_ld),
    .in_opt(in_opt), .in_src1(in_src1), .in_src2(in_src2), .in_val1(in_val1),
    .in_val2(in_val2), .in_imm(in_imm), .in_rob_idx(in_rob_idx),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
    .rs_full(rs_full), .slb_full(slb_full), .rs_ena(rs_ena), .slb_ena(slb_ena),
    .out_opt(out_opt), .out_src1(out_src1), .out_src2(out_src2), .out_val1(out_val1),
    .out_val2(out_val2), .out_imm(out_imm), .out_rob_idx(out_rob_idx),
    .out_is_ld(out_is_ld), .count(count)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state and counters
  logic [EXP_W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int win_cnt = 0;
  int win_first = 0;
  int win_last = 0;
  int cnt_max = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // output monitor: every issue pops and compares the oldest expected bundle
  bundle_t          mon_got;
  logic [EXP_W-1:0] mon_raw;
  logic [EXP_W-1:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && (rs_ena || slb_ena)) begin
      mon_got.is_ls = slb_ena;
      mon_got.is_ld = out_is_ld;
      mon_got.opt   = out_opt;
      mon_got.rob   = out_rob_idx;
      mon_got.src1  = out_src1;
      mon_got.src2  = out_src2;
      mon_got.val1  = out_val1;
      mon_got.val2  = out_val2;
      mon_got.imm   = out_imm;
      mon_raw = mon_got;
      check("ena_exclusive", 128'(rs_ena & slb_ena), 128'(0));
      check("issue_pending", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("issue_bundle", 128'(mon_raw), 128'(mon_exp));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rs_ena || slb_ena) begin
      if (win_cnt == 0) win_first = cyc;
      win_last = cyc;
      win_cnt++;
    end
    if (int'(count) > cnt_max) cnt_max = int'(count);
  endtask

  task automatic clr_win();
    win_cnt = 0;
    win_first = 0;
    win_last = 0;
  endtask

  function automatic bundle_t mk(input logic ls, input logic ld, input logic [ROB_W-1:0] rob,
                                 input logic [ROB_W-1:0] s1, input logic [WORD_W-1:0] v1,
                                 input logic [ROB_W-1:0] s2, input logic [WORD_W-1:0] v2);
    bundle_t b;
    b.is_ls = ls;
    b.is_ld = ld;
    b.opt   = OPT_W'($urandom_range(0, 63));
    b.rob   = rob;
    b.src1  = s1;
    b.src2  = s2;
    b.val1  = v1;
    b.val2  = v2;
    b.imm   = $urandom;
    return b;
  endfunction

  task automatic offer(input bundle_t b, input bundle_t e, input logic acc);
    in_is_ls   = b.is_ls;
    in_is_ld   = b.is_ld;
    in_opt     = b.opt;
    in_rob_idx = b.rob;
    in_src1    = b.src1;
    in_src2    = b.src2;
    in_val1    = b.val1;
    in_val2    = b.val2;
    in_imm     = b.imm;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bundle_t b, e;
    rst = 1'b1; rdy = 1'b1; rb = 1'b0; in_valid = 1'b0;
    in_is_ls = 1'b0; in_is_ld = 1'b0; in_opt = '0; in_src1 = '0; in_src2 = '0;
    in_val1 = '0; in_val2 = '0; in_imm = '0; in_rob_idx = '0;
    cdb_valid = '0; cdb_src = '0; cdb_val = '0; rs_full = 1'b0; slb_full = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_count", 128'(count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_rs_ena", 128'(rs_ena), 128'(0));
    check("rst_slb_ena", 128'(slb_ena), 128'(0));
    check("rst_out", 128'({out_rob_idx, out_val1, out_imm, out_is_ld}), 128'(0));

    // fill/drain with a free RS
    cnt_max = 0;
    clr_win();
    for (int r = 1; r <= 4; r++) begin
      b = mk(1'b0, 1'b0, ROB_W'(r), '0, $urandom, '0, $urandom);
      offer(b, b, 1'b1);
      if (r == 1) acc_cyc = cyc;
    end
    drain("fill_drain");
    check("fill_ena_cycles", 128'(win_cnt), 128'(4));
    check("fill_first_ena", 128'(win_first), 128'(acc_cyc + 1));
    check("fill_consecutive", 128'(win_last - win_first), 128'(3));
    check("fill_peak_count", 128'(cnt_max), 128'(1));

    // back-pressure, refusal when full, then wrap
    rs_full = 1'b1;
    clr_win();
    for (int r = 5; r <= 8; r++) begin
      b = mk(1'b0, 1'b0, ROB_W'(r), '0, $urandom, '0, $urandom);
      offer(b, b, 1'b1);
    end
    check("bp_count_full", 128'(count), 128'(4));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    b = mk(1'b0, 1'b0, 4'd9, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b0);
    check("bp_count_hold", 128'(count), 128'(4));
    check("bp_no_ena", 128'(win_cnt), 128'(0));
    rs_full = 1'b0;
    tick();
    for (int r = 10; r <= 12; r++) begin
      b = mk(1'b0, 1'b0, ROB_W'(r), '0, $urandom, '0, $urandom);
      offer(b, b, 1'b1);
    end
    drain("wrap_drain");
    check("wrap_count_end", 128'(count), 128'(0));

    // snoop while waiting: single match, src 0 ignored, lowest channel wins
    rs_full = 1'b1;
    b = mk(1'b0, 1'b0, 4'd1, 4'd3, 32'h0, 4'd0, 32'h1234);
    e = b; e.src1 = '0; e.val1 = 32'hDEADBEEF;
    offer(b, e, 1'b1);
    cdb_valid = 2'b11; cdb_src = {4'd0, 4'd3}; cdb_val = {32'h0BAD, 32'hDEADBEEF};
    tick();
    cdb_valid = 2'b00;
    b = mk(1'b0, 1'b0, 4'd2, 4'd6, 32'h0, 4'd9, 32'h42);
    e = b; e.src1 = '0; e.val1 = 32'h11;
    offer(b, e, 1'b1);
    cdb_valid = 2'b11; cdb_src = {4'd6, 4'd6}; cdb_val = {32'h22, 32'h11};
    tick();
    cdb_valid = 2'b00;
    rs_full = 1'b0;
    drain("snoop_drain");

    // broadcast on the issue edge is captured into out_*
    rs_full = 1'b1;
    b = mk(1'b0, 1'b0, 4'd3, 4'd8, 32'h0, 4'd0, 32'h5);
    e = b; e.src1 = '0; e.val1 = 32'hCAFE;
    offer(b, e, 1'b1);
    rs_full = 1'b0;
    cdb_valid = 2'b10; cdb_src = {4'd8, 4'd0}; cdb_val = {32'hCAFE, 32'h0};
    tick();
    cdb_valid = 2'b00;
    drain("issue_snoop_drain");

    // broadcast on the accept edge is captured (load routed to SLB)
    b = mk(1'b1, 1'b1, 4'd4, 4'd0, 32'h10, 4'd5, 32'h0);
    e = b; e.src2 = '0; e.val2 = 32'h7;
    cdb_valid = 2'b10; cdb_src = {4'd5, 4'd0}; cdb_val = {32'h7, 32'h0};
    offer(b, e, 1'b1);
    cdb_valid = 2'b00;
    drain("accept_snoop_drain");

    // routing: blocked store at head holds back a younger ALU op
    slb_full = 1'b1;
    clr_win();
    b = mk(1'b1, 1'b0, 4'd5, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b1);
    b = mk(1'b0, 1'b0, 4'd6, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b1);
    tick();
    tick();
    check("route_no_ena", 128'(win_cnt), 128'(0));
    check("route_count", 128'(count), 128'(2));
    slb_full = 1'b0;
    drain("route_drain");
    check("route_ena_cycles", 128'(win_cnt), 128'(2));
    check("route_back_to_back", 128'(win_last - win_first), 128'(1));

    // rollback flushes buffered entries and the bundle offered with it
    rs_full = 1'b1;
    for (int r = 7; r <= 9; r++) begin
      b = mk(1'b0, 1'b0, ROB_W'(r), '0, $urandom, '0, $urandom);
      offer(b, b, 1'b1);
    end
    check("rb_count_pre", 128'(count), 128'(3));
    exp_q.delete();
    rb = 1'b1;
    b = mk(1'b0, 1'b0, 4'd10, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b0);
    rb = 1'b0;
    check("rb_count", 128'(count), 128'(0));
    check("rb_ena", 128'(rs_ena | slb_ena), 128'(0));
    clr_win();
    rs_full = 1'b0;
    repeat (3) tick();
    check("rb_quiet", 128'(win_cnt), 128'(0));
    b = mk(1'b0, 1'b0, 4'd13, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b1);
    drain("rb_after_drain");

    // freeze: no enqueue, issue or snoop while rdy is low
    rs_full = 1'b1;
    b = mk(1'b0, 1'b0, 4'd14, 4'd2, 32'h1, 4'd0, 32'h3);
    offer(b, b, 1'b1);
    b = mk(1'b0, 1'b0, 4'd15, '0, $urandom, '0, $urandom);
    offer(b, b, 1'b1);
    check("frz_count_pre", 128'(count), 128'(2));
    rdy = 1'b0;
    rs_full = 1'b0;
    in_valid = 1'b1;
    cdb_valid = 2'b01; cdb_src = {4'd0, 4'd2}; cdb_val = {32'h0, 32'h99};
    clr_win();
    repeat (3) begin
      tick();
      check("frz_count", 128'(count), 128'(2));
      check("frz_out_rob", 128'(out_rob_idx), 128'(13));
    end
    check("frz_no_ena", 128'(win_cnt), 128'(0));
    rdy = 1'b1;
    in_valid = 1'b0;
    cdb_valid = 2'b00;
    drain("frz_drain");
    check("final_count", 128'(count), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised issue buffer between the rename/decode stage and the reservation station (RS) and store/load buffer (SLB). It holds up to DEPTH renamed instruction bundles in FIFO order. Every entry snoops CDB_N result broadcast channels each cycle so that it captures operands while waiting. The oldest entry is issued to RS or SLB as soon as that target has room, which decouples decode from back-pressure in the execution queues.

## Interface
- DEPTH, 4, number of buffered entries; power of two, ≥2
- CDB_N, 2, number of CDB broadcast channels snooped
- ROB_W, 4, ROB index width; index 0 means "operand ready"
- OPT_W, 6, opcode field width
- WORD_W, 32, data width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- rb  in  1  rollback; flushes the queue
- in_valid  in  1  bundle offered
- in_ready  out  1  combinational, = (count != DEPTH)
- in_is_ls, in_is_ld  in  1 each  route to SLB; load (vs store)
- in_opt  in  OPT_W  opcode
- in_src1, in_src2  in  ROB_W each  producer ROB index, 0 = ready
- in_val1, in_val2, in_imm  in  WORD_W each  operand values and immediate
- in_rob_idx  in  ROB_W  destination ROB entry
- cdb_valid  in  CDB_N  per-channel valid
- cdb_src  in  CDB_N*ROB_W  channel i at bits [i*ROB_W +: ROB_W]
- cdb_val  in  CDB_N*WORD_W  channel i at bits [i*WORD_W +: WORD_W]
- rs_full, slb_full  in  1 each  target cannot accept at this edge
- rs_ena, slb_ena  out  1 each  one-cycle issue pulses
- out_opt, out_src1, out_src2, out_val1, out_val2, out_imm, out_rob_idx, out_is_ld  out  registered issued bundle
- count  out  clog2(DEPTH)+1  occupancy

## Operation
- **Storage.** Circular buffer with head and tail pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH. count saturates neither up nor down: enqueue is blocked when full, and issue only happens when the queue is non-empty.
- **Snoop.** Every cycle, each valid entry compares src1 and src2 against every channel with cdb_valid set.
  - On a match: src ← 0 and val ← the channel's value.
  - If several channels match, the lowest channel index wins.
  - A src of 0 never matches.
  - An incoming bundle is snooped the same way before it is written.
- **Issue.** At an edge where count>0, the head entry is issued if its target is not full (SLB when is_ls, otherwise RS).
  - The out_* registers load the head entry with that cycle's snoop already applied.
  - rs_ena or slb_ena is set to 1 for exactly one cycle.
  - head advances.
  - Issue is strictly in order: a blocked head also blocks younger entries even when their target is free.
- **Enqueue.** When in_valid && in_ready, the bundle is written at tail and tail advances.
  - Enqueue and issue in the same cycle leave count unchanged.
  - Enqueue is gated by the pre-edge count. There is no same-cycle credit from an issue, so a full queue refuses input even while it is draining.
- **Rollback.** rb takes priority over everything except rst.
  - head, tail and count ← 0.
  - Enables are 0 next cycle.
  - The incoming bundle is dropped.
- **Freeze.** With rdy low and rb low, no state changes and enables are 0.
- **Reset values.** count, head and tail = 0; rs_ena and slb_ena = 0; all out_* = 0.

## Timing
- Enables default to 0 every edge and are asserted only in the cycle following an issue edge.
- Minimum latency: a bundle accepted at edge k can issue at edge k+1, with its enable high during cycle k+1→k+2. There is no empty-queue bypass.
- A CDB broadcast in the same cycle as acceptance or issue is captured. A broadcast on a cycle when no entry holds the matching index is lost; the ROB value path covers that case.
- Throughput: one issue per cycle.
- Priority at an edge: rst > rb > !rdy > issue/enqueue/snoop (these three run concurrently).

## Test plan
- **Fill/drain.** Reset, then enqueue 4 ALU bundles with rob_idx 1..4, src=0, rs_full=0.
  - rs_ena is high for 4 consecutive cycles, starting the cycle after the first accept.
  - out_rob_idx reads 1, 2, 3, 4.
  - count peaks at 1.
- **Back-pressure/wrap.** Hold rs_full=1 and enqueue 5 bundles.
  - count=4, in_ready=0, and the 5th bundle is not accepted.
  - Release rs_full, then enqueue 3 more: tail wraps, and issue order remains strictly FIFO.
- **Snoop.** Buffer an entry with src1=3, then drive cdb_valid=2'b01, cdb_src ch0=3, cdb_val=0xDEADBEEF; later release rs_full.
  - Issued out_src1=0 and out_val1=0xDEADBEEF.
  - Both channels matching with ch0=0x11 and ch1=0x22 gives out_val1=0x11.
- **Same-cycle capture.** Offer in_src2=5 while channel 1 broadcasts index 5 with value 0x7.
  - The issued bundle has src2=0 and val2=0x7.
- **Routing/blocking.** Enqueue a store, then an ALU op, with slb_full=1 and rs_full=0.
  - No enable fires.
  - Drop slb_full: slb_ena fires, with out_is_ld=0, then rs_ena fires the next cycle.
- **Rollback/freeze.**
  - With 3 entries buffered, pulse rb: count=0 next cycle, no enables, and the simultaneously offered bundle is absent.
  - With rdy=0 for 3 cycles at count=2: count and outputs are unchanged and the enables stay 0.
